ahblite_dec_mux: RTL and testbench

//  Next-generation AHB-Lite address decoder plus slave-to-master response multiplexer for the M0 subsystem.

---
 rtl/ahblite_dec_mux_if.sv | 27 ++
 rtl/ahblite_dec_mux.sv | 121 ++++++++++++
 tb/tb_ahblite_dec_mux.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ahblite_dec_mux_if.sv
// AHB-Lite bus bundle between the master/slave fabric and the decoder/mux.
// The master modport is the fabric side: the master drives address and
// transfer type, the slaves drive their ready/response/data vectors.
// The slave modport is the decoder/mux side.
interface ahblite_dec_mux_if #(
  parameter int NPORT = 8
);
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic [NPORT-1:0]    HSEL_S;
  logic [NPORT-1:0]    HREADYOUT_S;
  logic [NPORT-1:0]    HRESP_S;
  logic [NPORT*32-1:0] HRDATA_S;
  logic                HREADY;
  logic                HRESP;
  logic [31:0]         HRDATA;

  modport master (
    output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HSEL_S, HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HSEL_S, HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_dec_mux.sv
// AHB-Lite address decoder and response multiplexer with a built-in default
// slave. Each port owns one 64 KB region selected by HADDR[31:16]; anything
// that hits no enabled port is answered by the default slave, which gives a
// two-cycle ERROR to active transfers and logs the offending address.
module ahblite_dec_mux #(
  parameter int                  NPORT     = 8,
  parameter logic [NPORT*16-1:0] PORT_BASE = {16'h4004, 16'h4003, 16'h3000, 16'h4002,
                                              16'h4001, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [NPORT-1:0]    PORT_EN   = '1
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  ahblite_dec_mux_if.slave        bus,
  input  logic                    ERR_CLR,
  output logic [15:0]             ERR_CNT,
  output logic [31:0]             ERR_ADDR
);

  // One extra select code beyond the real ports stands for the default slave.
  localparam int              SELW = $clog2(NPORT + 1);
  localparam logic [SELW-1:0] DEF  = SELW'(NPORT);

  typedef enum logic [1:0] {
    IDLE,
    ERR1,
    ERR2
  } def_state_t;

  logic [NPORT-1:0] hsel;
  logic [SELW-1:0]  hit_idx;
  logic             unmapped;
  logic [SELW-1:0]  sel_q;
  def_state_t       state_q;
  def_state_t       state_d;
  logic             hready;
  logic             hresp;
  logic [31:0]      hrdata;
  logic             take_err;
  logic [15:0]      err_cnt_q;
  logic [31:0]      err_addr_q;

  // Address decode: the lowest-numbered enabled port that matches wins, so HSEL_S stays one-hot or zero.
  always_comb begin
    hsel     = '0;
    hit_idx  = DEF;
    unmapped = 1'b1;
    for (int i = 0; i < NPORT; i++) begin
      if (unmapped && PORT_EN[i] && (bus.HADDR[31:16] == PORT_BASE[16*i +: 16])) begin
        hsel[i]  = 1'b1;
        hit_idx  = SELW'(i);
        unmapped = 1'b0;
      end
    end
  end

  // Response mux: steer the data-phase owner's signals, or the default slave's own response.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (sel_q == DEF) begin
      hready = (state_q != ERR1);
      hresp  = (state_q != IDLE);
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (sel_q == SELW'(i)) begin
          hready = bus.HREADYOUT_S[i];
          hresp  = bus.HRESP_S[i];
          hrdata = bus.HRDATA_S[32*i +: 32];
        end
      end
    end
  end

  // An unmapped active transfer accepted this cycle starts a new ERROR response.
  assign take_err = hready && unmapped && bus.HTRANS[1];

  // Default slave next state: ERR1 always moves on to ERR2; ERR2 re-samples the next address phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_err) state_d = ERR1;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = take_err ? ERR1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data-phase owner and default slave state; the owner only advances when the bus is ready.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q   <= DEF;
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      if (hready) sel_q <= hit_idx;
    end
  end

  // Error log: saturating count of ERROR responses and the address that caused the latest one.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (take_err) begin
      err_addr_q <= bus.HADDR;
      if (ERR_CLR)                   err_cnt_q <= 16'd1;
      else if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end else if (ERR_CLR) begin
      err_cnt_q <= '0;
    end
  end

  assign bus.HSEL_S = hsel;
  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;
  assign ERR_CNT    = err_cnt_q;
  assign ERR_ADDR   = err_addr_q;

endmodule

// File: tb/tb_ahblite_dec_mux.sv
// Directed bench for ahblite_dec_mux: a table of per-cycle vectors covering
// decode, wait states, unmapped ERROR sequences and the error log, then
// hand-written sequences for counter saturation and reset during ERR1.
module tb_ahblite_dec_mux;

  localparam int NPORT = 8;
  // Port 6 deliberately overlaps port 1 and port 4 is disabled.
  localparam logic [NPORT*16-1:0] BASES = {16'h4004, 16'h2000, 16'h4003, 16'h4002,
                                           16'h4001, 16'h4000, 16'h2000, 16'h0000};
  localparam logic [NPORT-1:0]    ENS   = 8'hEF;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [7:0]  readyout;
    logic [7:0]  resp_s;
    logic        clr;
    logic [7:0]  exp_hsel;
    logic        exp_hready;
    logic        exp_hresp;
    logic [31:0] exp_hrdata;
    logic [15:0] exp_cnt;
    logic [31:0] exp_addr;
  } vec_t;

  logic        HCLK;
  logic        HRESET;
  logic        err_clr;
  logic [15:0] err_cnt;
  logic [31:0] err_addr;
  int          tests_run;
  int          tests_failed;
  vec_t        vecs [22];

  ahblite_dec_mux_if #(.NPORT(NPORT)) bus ();

  ahblite_dec_mux #(
    .NPORT    (NPORT),
    .PORT_BASE(BASES),
    .PORT_EN  (ENS)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .bus     (bus.slave),
    .ERR_CLR (err_clr),
    .ERR_CNT (err_cnt),
    .ERR_ADDR(err_addr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.HADDR       = v.haddr;
    bus.HTRANS      = v.htrans;
    bus.HREADYOUT_S = v.readyout;
    bus.HRESP_S     = v.resp_s;
    err_clr         = v.clr;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d_hsel", idx),   32'(bus.HSEL_S), 32'(v.exp_hsel));
    checkOutput($sformatf("v%0d_hready", idx), 32'(bus.HREADY), 32'(v.exp_hready));
    checkOutput($sformatf("v%0d_hresp", idx),  32'(bus.HRESP),  32'(v.exp_hresp));
    checkOutput($sformatf("v%0d_hrdata", idx), bus.HRDATA,      v.exp_hrdata);
    checkOutput($sformatf("v%0d_errcnt", idx), 32'(err_cnt),    32'(v.exp_cnt));
    checkOutput($sformatf("v%0d_erraddr", idx), err_addr,       v.exp_addr);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Each row: inputs for one cycle and the outputs expected before that cycle's edge.
    //            haddr         trans  rdy    resp   clr   hsel   rdy   rsp   hrdata          cnt     addr
    vecs[0]  = '{32'h2000_0010, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 32'h0,          16'd0, 32'h0};
    vecs[1]  = '{32'h4001_0004, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0, 32'hDA7A_0001, 16'd0, 32'h0};
    vecs[2]  = '{32'h4000_0000, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 32'hDA7A_0003, 16'd0, 32'h0};
    vecs[3]  = '{32'h0000_0100, 2'b10, 8'hFB, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 32'hDA7A_0002, 16'd0, 32'h0};
    vecs[4]  = '{32'h0000_0100, 2'b10, 8'hFB, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 32'hDA7A_0002, 16'd0, 32'h0};
    vecs[5]  = '{32'h0000_0100, 2'b10, 8'hFB, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 32'hDA7A_0002, 16'd0, 32'h0};
    vecs[6]  = '{32'h0000_0100, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 32'hDA7A_0002, 16'd0, 32'h0};
    vecs[7]  = '{32'h5000_0000, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'hDA7A_0000, 16'd0, 32'h0};
    vecs[8]  = '{32'h0000_0100, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 32'h0,          16'd1, 32'h5000_0000};
    vecs[9]  = '{32'h0000_0100, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1, 32'h0,          16'd1, 32'h5000_0000};
    vecs[10] = '{32'h5000_0000, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'hDA7A_0000, 16'd1, 32'h5000_0000};
    vecs[11] = '{32'h5000_0000, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          16'd1, 32'h5000_0000};
    vecs[12] = '{32'h4002_0000, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          16'd1, 32'h5000_0000};
    vecs[13] = '{32'h6000_0000, 2'b11, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,          16'd2, 32'h4002_0000};
    vecs[14] = '{32'h6000_0000, 2'b11, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0,          16'd2, 32'h4002_0000};
    vecs[15] = '{32'h2000_0000, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 32'h0,          16'd3, 32'h6000_0000};
    vecs[16] = '{32'h2000_0000, 2'b10, 8'hFF, 8'h00, 1'b1, 8'h02, 1'b1, 1'b1, 32'h0,          16'd3, 32'h6000_0000};
    vecs[17] = '{32'h4004_0008, 2'b10, 8'hFF, 8'h02, 1'b0, 8'h80, 1'b1, 1'b1, 32'hDA7A_0001, 16'd0, 32'h6000_0000};
    vecs[18] = '{32'h7000_0000, 2'b10, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 32'hDA7A_0007, 16'd0, 32'h6000_0000};
    vecs[19] = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 32'h0,          16'd1, 32'h7000_0000};
    vecs[20] = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1, 32'h0,          16'd1, 32'h7000_0000};
    vecs[21] = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 32'hDA7A_0000, 16'd1, 32'h7000_0000};

    for (int i = 0; i < NPORT; i++) bus.HRDATA_S[32*i +: 32] = 32'hDA7A_0000 + 32'(i);
    bus.HADDR       = 32'h4000_0000;
    bus.HTRANS      = 2'b00;
    bus.HREADYOUT_S = 8'hFF;
    bus.HRESP_S     = 8'h00;
    err_clr         = 1'b0;
    HRESET          = 1'b1;

    tick;
    tick;
    checkOutput("rst_hsel_comb", 32'(bus.HSEL_S), 32'h04);
    bus.HADDR = 32'h5000_0000;
    tick;
    HRESET = 1'b0;
    #1;
    checkOutput("rst_hready", 32'(bus.HREADY), 32'h1);
    checkOutput("rst_hresp",  32'(bus.HRESP),  32'h0);
    checkOutput("rst_hrdata", bus.HRDATA,      32'h0);
    checkOutput("rst_errcnt", 32'(err_cnt),    32'h0);
    checkOutput("rst_erraddr", err_addr,       32'h0);
    checkOutput("rst_hsel",   32'(bus.HSEL_S), 32'h0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
      tick;
    end

    // Saturation: preload the counter just below its ceiling, then drive back-to-back unmapped transfers.
    dut.err_cnt_q   = 16'hFFFE;
    err_clr         = 1'b0;
    bus.HRESP_S     = 8'h00;
    bus.HREADYOUT_S = 8'hFF;
    bus.HADDR       = 32'h5000_0010;
    bus.HTRANS      = 2'b10;
    #1;
    checkOutput("sat_pre_hready", 32'(bus.HREADY), 32'h1);
    tick;
    checkOutput("sat_reach",      32'(err_cnt),    32'hFFFF);
    checkOutput("sat_err1_ready", 32'(bus.HREADY), 32'h0);
    tick;
    checkOutput("sat_err2_resp",  32'(bus.HRESP),  32'h1);
    checkOutput("sat_err2_ready", 32'(bus.HREADY), 32'h1);
    tick;
    checkOutput("sat_hold",       32'(err_cnt),    32'hFFFF);
    checkOutput("sat_addr",       err_addr,        32'h5000_0010);
    checkOutput("sat_err1_again", 32'(bus.HREADY), 32'h0);

    // Reset while the default slave sits in ERR1.
    HRESET = 1'b1;
    tick;
    HRESET     = 1'b0;
    bus.HADDR  = 32'h0000_0100;
    bus.HTRANS = 2'b10;
    #1;
    checkOutput("rerr_hready",  32'(bus.HREADY), 32'h1);
    checkOutput("rerr_hresp",   32'(bus.HRESP),  32'h0);
    checkOutput("rerr_hrdata",  bus.HRDATA,      32'h0);
    checkOutput("rerr_errcnt",  32'(err_cnt),    32'h0);
    checkOutput("rerr_erraddr", err_addr,        32'h0);
    checkOutput("rerr_hsel",    32'(bus.HSEL_S), 32'h01);
    tick;
    bus.HTRANS = 2'b00;
    #1;
    checkOutput("rerr_port0_data",  bus.HRDATA,      32'hDA7A_0000);
    checkOutput("rerr_port0_ready", 32'(bus.HREADY), 32'h1);
    checkOutput("rerr_port0_resp",  32'(bus.HRESP),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
